// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and status-flag layout for seq_alu.
// Combinational definitions only; no latency or backpressure of its own.
// Flag bit order is {V, C, N, Z} with Z in bit 0.
package alu_pkg;

    localparam int OP_ADD   = 0;
    localparam int OP_SHL   = 1;
    localparam int OP_SHR   = 2;
    localparam int OP_OR    = 3;
    localparam int OP_AND   = 4;
    localparam int OP_ADD5  = 5;
    localparam int OP_PASS  = 6;
    localparam int OP_ADD7  = 7;
    localparam int OP_ADD8  = 8;
    localparam int OP_SUB   = 9;
    localparam int OP_MUL   = 10;
    localparam int OP_XOR   = 11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Latency: start loads at edge t, done is high after WIDTH further steps.
// No backpressure: a new start simply overwrites any operation in flight.
module seq_alu_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               running;

    assign done    = running && (cnt == '0);
    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            if (cnt != '0) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end else begin
                // done was visible for one cycle; the parent has captured the product
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result/flags; MUL only when SEQ_ALU_MUL_EN is defined.
// Latency: 1 cycle for all ops, WIDTH+1 cycles for MUL (accept to out_valid).
// Backpressure: result held while out_ready=0; in_ready follows out_ready in DONE.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  ALUselect,
    input  logic [WIDTH-1:0]  ALUin1,
    input  logic [WIDTH-1:0]  ALUin2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  ALUout,
    output logic [3:0]        flags
);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_res;
    flags_t             mul_flg;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res_c;
    logic               carry;
    logic               ovf;
    flags_t             flg_c;
    flags_t             flags_q;

    assign accept = in_valid && in_ready;
    assign flags  = flags_q;

    // single-cycle datapath; carry/borrow taken from bit WIDTH of a WIDTH+1 wide op
    always_comb begin
        sum   = {1'b0, ALUin1} + {1'b0, ALUin2};
        diff  = {1'b0, ALUin1} - {1'b0, ALUin2};
        res_c = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (ALUselect)
            SEL_W'(OP_ADD), SEL_W'(OP_ADD5), SEL_W'(OP_ADD7), SEL_W'(OP_ADD8): begin
                res_c = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (ALUin1[WIDTH-1] == ALUin2[WIDTH-1]) &&
                        (sum[WIDTH-1] != ALUin1[WIDTH-1]);
            end
            SEL_W'(OP_SUB): begin
                res_c = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (ALUin1[WIDTH-1] != ALUin2[WIDTH-1]) &&
                        (diff[WIDTH-1] != ALUin1[WIDTH-1]);
            end
            // shift by the full B value: amounts >= WIDTH shift everything out
            SEL_W'(OP_SHL):  res_c = ALUin1 << ALUin2;
            SEL_W'(OP_SHR):  res_c = ALUin1 >> ALUin2;
            SEL_W'(OP_OR):   res_c = ALUin1 | ALUin2;
            SEL_W'(OP_AND):  res_c = ALUin1 & ALUin2;
            SEL_W'(OP_PASS): res_c = ALUin2;
            SEL_W'(OP_XOR):  res_c = ALUin1 ^ ALUin2;
            default:         res_c = '0;
        endcase
        flg_c.v = ovf;
        flg_c.c = carry;
        flg_c.n = res_c[WIDTH-1];
        flg_c.z = (res_c == '0);
    end

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] product;
    logic               mul_start;
    logic               mul_hi;

    assign is_mul    = (ALUselect == SEL_W'(OP_MUL));
    assign mul_start = accept && is_mul;

    seq_alu_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (ALUin1),
        .b       (ALUin2),
        .done    (mul_done),
        .product (product)
    );

    assign mul_res   = product[WIDTH-1:0];
    assign mul_hi    = (product[2*WIDTH-1:WIDTH] != '0);
    assign mul_flg.v = mul_hi;
    assign mul_flg.c = mul_hi;
    assign mul_flg.n = mul_res[WIDTH-1];
    assign mul_flg.z = (mul_res == '0);
`else
    // opcode 10 falls through to the zero-result default of the datapath
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_flg  = '0;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = is_mul ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_nxt = is_mul ? BUSY : DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ALUout  <= '0;
            flags_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !is_mul) begin
                ALUout  <= res_c;
                flags_q <= flg_c;
            end else if (mul_done) begin
                ALUout  <= mul_res;
                flags_q <= mul_flg;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and randomized bench for seq_alu against a plain-arithmetic reference model.
module tb_seq_alu;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ALUselect;
    logic [W-1:0]  ALUin1;
    logic [W-1:0]  ALUin2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ALUout;
    logic [3:0]    flags;

    int checks = 0;
    int passed = 0;

    seq_alu #(.WIDTH(W), .SEL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUselect (ALUselect),
        .ALUin1    (ALUin1),
        .ALUin2    (ALUin2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUout    (ALUout),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // returns {V, C, N, Z, result}
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua, ub, r;
        int sa, sb, sr;
        logic c, v;
        logic [15:0] res;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        r = 0; c = 0; v = 0;
        case (op)
            0, 5, 7, 8: begin
                r  = ua + ub;
                c  = (r > 65535);
                sr = sa + sb;
                v  = (sr > 32767) || (sr < -32768);
            end
            1:  r = (ub >= 16) ? 0 : (ua << ub);
            2:  r = (ub >= 16) ? 0 : (ua >> ub);
            3:  r = ua | ub;
            4:  r = ua & ub;
            6:  r = ub;
            9: begin
                r  = ua - ub;
                c  = (ua < ub);
                sr = sa - sb;
                v  = (sr > 32767) || (sr < -32768);
            end
`ifdef SEQ_ALU_MUL_EN
            10: begin
                r = ua * ub;
                c = (r >= 65536);
                v = c;
            end
`endif
            11: r = ua ^ ub;
            default: r = 0;
        endcase
        res = r[15:0];
        return {v, c, res[15], (res == 16'h0), res};
    endfunction

    function automatic int exp_latency(input logic [3:0] op);
`ifdef SEQ_ALU_MUL_EN
        if (op == 4'd10) return W + 1;
`endif
        return 1;
    endfunction

    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int stall);
        logic [19:0] e;
        int lat;
        e = model(op, a, b);
        in_valid  = 1'b1;
        ALUselect = op;
        ALUin1    = a;
        ALUin2    = b;
        out_ready = 1'b0;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        // inputs wander after accept; the captured operands must be used
        in_valid  = 1'b0;
        ALUselect = 4'($urandom);
        ALUin1    = 16'($urandom);
        ALUin2    = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_latency(op));
        chk({tag, "_aluout"}, {16'd0, ALUout}, {16'd0, e[15:0]});
        chk({tag, "_flags"}, {28'd0, flags}, {28'd0, e[19:16]});
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            chk({tag, "_held"}, {11'd0, out_valid, flags, ALUout}, {11'd0, 1'b1, e});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [19:0] e0, e1, e2;
        logic        stale;
        logic [3:0]  op;
        logic [15:0] a, b;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALUselect = '0; ALUin1 = '0; ALUin2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_aluout", {16'd0, ALUout}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);

        do_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 0);
        chk("add_ovf_const", {12'd0, flags, ALUout}, {12'd0, 4'b1010, 16'h8000});
        do_op("sub_borrow", 4'd9, 16'd3, 16'd5, 0);
        chk("sub_const", {12'd0, flags, ALUout}, {12'd0, 4'b0110, 16'hFFFE});
        do_op("shl_16", 4'd1, 16'd1, 16'd16, 0);
        chk("shl_const", {12'd0, flags, ALUout}, {12'd0, 4'b0001, 16'h0000});
        do_op("mul_hi", 4'd10, 16'h0100, 16'h0100, 2);
        do_op("op14", 4'd14, 16'hFFFF, 16'hFFFF, 0);
        chk("op14_const", {12'd0, flags, ALUout}, {12'd0, 4'b0001, 16'h0000});

        // back-to-back stream then backpressure
        e0 = model(4'd0, 16'h1234, 16'h1111);
        e1 = model(4'd3, 16'hF000, 16'h000F);
        e2 = model(4'd6, 16'hAAAA, 16'h5555);
        out_ready = 1'b1; in_valid = 1'b1;
        ALUselect = 4'd0; ALUin1 = 16'h1234; ALUin2 = 16'h1111;
        @(posedge clk); #1;
        chk("b2b_r0", {11'd0, out_valid, flags, ALUout}, {11'd0, 1'b1, e0});
        ALUselect = 4'd3; ALUin1 = 16'hF000; ALUin2 = 16'h000F;
        @(posedge clk); #1;
        chk("b2b_r1", {11'd0, out_valid, flags, ALUout}, {11'd0, 1'b1, e1});
        ALUselect = 4'd6; ALUin1 = 16'hAAAA; ALUin2 = 16'h5555;
        @(posedge clk); #1;
        chk("b2b_r2", {11'd0, out_valid, flags, ALUout}, {11'd0, 1'b1, e2});
        out_ready = 1'b0;
        ALUselect = 4'd11; ALUin1 = 16'h0F0F; ALUin2 = 16'h00FF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", {10'd0, in_ready, out_valid, flags, ALUout}, {10'd0, 1'b0, 1'b1, e2});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // reset during a multiply
        in_valid = 1'b1; ALUselect = 4'd10; ALUin1 = 16'h1234; ALUin2 = 16'h5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", {12'd0, in_ready, out_valid, flags, ALUout}, {12'd0, 1'b1, 1'b0, 4'd0, 16'd0});
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        out_ready = 1'b0;
        chk("abort_no_stale", {31'd0, stale}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 20));
            do_op("rand", op, a, b, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
